// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: memory port A read request/response, branch redirect
// and the instruction hand-off to decode.
interface fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // Decode handshake: a word transfers in every cycle with instr_valid & instr_ready;
  // while instr_valid=1 and instr_ready=0, instr and instr_pc are held unchanged.
  modport master (
    output mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    input  mem_rdata, branch_valid, branch_target, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, instr, instr_pc, instr_valid,
    output mem_rdata, branch_valid, branch_target, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential reads from memory port A into a 2-entry
// buffer, decode hand-off over valid/ready, branch redirect with flush.
module fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus_io,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q;

  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic              inflight_q,    inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q,       count_d;
  logic              rd_ptr_q,      rd_ptr_d;
  logic              wr_ptr_q,      wr_ptr_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [ADDR_W-1:0] buf_pc_q   [2];

  logic              head_valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic              kill;
  logic              redirect;
  logic [2:0]        occupancy;

  assign head_valid = (count_q != 2'd0);
  assign pop        = head_valid & bus_io.instr_ready;

  // Words already buffered or on their way back, less the one leaving now,
  // must leave room for the word this request would bring back.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_RUN) & ~bus_io.branch_valid & (occupancy < 3'd2);

  assign redirect   = bus_io.branch_valid & (state_q != ST_RESET);
  assign kill       = bus_io.branch_valid | (state_q == ST_FLUSH);
  assign push       = inflight_q & ~kill;

  assign bus_io.mem_addr    = pc_q;
  assign bus_io.mem_rd_en   = issue;
  assign bus_io.instr_valid = head_valid;
  assign bus_io.instr       = buf_data_q[rd_ptr_q];
  assign bus_io.instr_pc    = buf_pc_q[rd_ptr_q];
  assign state_o            = state_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d      = rd_ptr_q ^ pop;
    wr_ptr_d      = wr_ptr_q ^ push;
    if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_pc_d = pc_q;
    end
    // Redirect empties the buffer; pointers realign so the next push is the head.
    if (redirect) begin
      pc_d     = bus_io.branch_target;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_RUN;
        ST_RUN:   state_q <= bus_io.branch_valid ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_q <= bus_io.branch_valid ? ST_FLUSH : ST_RUN;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus_io.mem_rdata;
        buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// queue-based reference model compared against the outputs every cycle.
module tb_fetch_unit;
  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFE;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dut_state;
  logic [1:0] wrap_state;
  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;

  fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus  ();
  fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wbus ();

  fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(32'd1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master),
    .state_o(dut_state)
  );

  fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(WRAP_PC), .PC_STEP(32'd1)) u_wrap (
    .clk    (clk),
    .rst    (rst),
    .bus_io (wbus.master),
    .state_o(wrap_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memories (1-cycle read latency) ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hD000_0000 + a;
  endfunction

  always @(posedge clk) if (bus.mem_rd_en)  bus.mem_rdata  <= mem_word(bus.mem_addr);
  always @(posedge clk) if (wbus.mem_rd_en) wbus.mem_rdata <= mem_word(wbus.mem_addr);

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [63:0] exp_q[$];     // {pc, word} held for decode, head first
  logic [31:0] pop_log[$];   // pcs of words accepted by decode
  logic [31:0] m_pc;
  logic [31:0] m_resp_a;
  bit          m_resp_v;
  bit          m_in_reset;
  bit          m_flush;
  bit          m_zero;
  bit          model_ok = 1'b0;

  function automatic logic [31:0] log_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin : compare_proc
    bit exp_valid;
    bit pop;
    bit issue;
    bit kill;
    int occ;
    if (bus.mem_rd_en === 1'b1) rd_cnt++;
    if (model_ok) begin
      exp_valid = (exp_q.size() > 0);
      pop       = exp_valid && (bus.instr_ready === 1'b1);
      occ       = exp_q.size() + (m_resp_v ? 1 : 0) - (pop ? 1 : 0);
      issue     = !m_in_reset && !m_flush && (bus.branch_valid !== 1'b1) && (occ < 2);
      check("mem_rd_en",   {63'd0, bus.mem_rd_en},   {63'd0, issue});
      check("mem_addr",    {32'd0, bus.mem_addr},    {32'd0, m_pc});
      check("instr_valid", {63'd0, bus.instr_valid}, {63'd0, exp_valid});
      if (exp_valid) begin
        check("instr_pc", {32'd0, bus.instr_pc}, {32'd0, exp_q[0][63:32]});
        check("instr",    {32'd0, bus.instr},    {32'd0, exp_q[0][31:0]});
      end else if (m_zero) begin
        check("instr_pc_zero", {32'd0, bus.instr_pc}, 64'd0);
        check("instr_zero",    {32'd0, bus.instr},    64'd0);
      end
    end
    if (rst) begin
      exp_q.delete();
      m_pc       = RESET_PC;
      m_resp_v   = 1'b0;
      m_resp_a   = '0;
      m_in_reset = 1'b1;
      m_flush    = 1'b0;
      m_zero     = 1'b1;
      model_ok   = 1'b1;
    end else if (model_ok) begin
      kill = (bus.branch_valid === 1'b1) || m_flush;
      if (pop) begin
        pop_log.push_back(exp_q[0][63:32]);
        void'(exp_q.pop_front());
      end
      if (m_resp_v && !kill) begin
        exp_q.push_back({m_resp_a, mem_word(m_resp_a)});
        m_zero = 1'b0;
      end
      if ((bus.branch_valid === 1'b1) && !m_in_reset) begin
        exp_q.delete();
        m_pc    = bus.branch_target;
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
      end
      m_in_reset = 1'b0;
      m_resp_v   = issue;
      if (issue) begin
        m_resp_a = m_pc;
        m_pc     = m_pc + 32'd1;
      end
    end
  end

  // A push into a full buffer without a simultaneous pop is a design error.
  always @(negedge clk) begin
    if (rst === 1'b0 && u_dut.push && u_dut.count_q == 2'd2 && !u_dut.pop) begin
      errors++;
      $display("FAIL buf_overflow: push into full buffer (t=%0t)", $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    rst              = 1'b1;
    bus.instr_ready  = rdy;
    bus.branch_valid = 1'b0;
    step(2);
    rst = 1'b0;
    pop_log.delete();
    rd_cnt = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [1:0] flush_code;
    rst               = 1'b1;
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    wbus.instr_ready   = 1'b1;
    wbus.branch_valid  = 1'b0;
    wbus.branch_target = '0;

    // Reset release, streaming, wrap instance, then branch at pc=3.
    step(2);
    @(negedge clk);
    check("rst_rd_en", {63'd0, bus.mem_rd_en},   64'd0);
    check("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("rst_instr", {32'd0, bus.instr},       64'd0);
    check("rst_pc",    {32'd0, bus.instr_pc},    64'd0);
    check("rst_addr",  {32'd0, bus.mem_addr},    64'd0);
    step(1);
    rst = 1'b0;
    pop_log.delete();
    @(negedge clk);                                    // c0
    check("c0_rd_en", {63'd0, bus.mem_rd_en},   64'd0);
    check("c0_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("w_c0_addr", {32'd0, wbus.mem_addr},  {32'd0, 32'hFFFF_FFFE});
    step(1); @(negedge clk);                           // c1
    check("c1_rd_en", {63'd0, bus.mem_rd_en}, 64'd1);
    check("c1_addr",  {32'd0, bus.mem_addr},  64'd0);
    check("w_c1_addr", {32'd0, wbus.mem_addr}, {32'd0, 32'hFFFF_FFFE});
    step(1); @(negedge clk);                           // c2
    check("c2_addr",  {32'd0, bus.mem_addr},    64'd1);
    check("c2_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("w_c2_addr", {32'd0, wbus.mem_addr},  {32'd0, 32'hFFFF_FFFF});
    step(1); @(negedge clk);                           // c3
    check("c3_addr",  {32'd0, bus.mem_addr},    64'd2);
    check("c3_valid", {63'd0, bus.instr_valid}, 64'd1);
    check("c3_instr", {32'd0, bus.instr},       {32'd0, 32'hD000_0000});
    check("c3_pc",    {32'd0, bus.instr_pc},    64'd0);
    check("w_c3_addr",  {32'd0, wbus.mem_addr}, 64'd0);
    check("w_c3_pc",    {32'd0, wbus.instr_pc}, {32'd0, 32'hFFFF_FFFE});
    check("w_c3_instr", {32'd0, wbus.instr},    {32'd0, 32'hCFFF_FFFE});
    step(1);                                           // c4: branch at pc=3
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h40;
    @(negedge clk);
    check("br_addr",  {32'd0, bus.mem_addr},  64'd3);
    check("br_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
    check("br_pc",    {32'd0, bus.instr_pc},  64'd1);
    check("w_c4_addr", {32'd0, wbus.mem_addr}, 64'd1);
    check("w_c4_pc",   {32'd0, wbus.instr_pc}, {32'd0, 32'hFFFF_FFFF});
    step(1);                                           // c5: flush
    bus.branch_valid = 1'b0;
    @(negedge clk);
    flush_code = dut_state;
    check("fl_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("fl_rd_en", {63'd0, bus.mem_rd_en},   64'd0);
    step(1); @(negedge clk);                           // c6
    check("tgt_rd_en", {63'd0, bus.mem_rd_en}, 64'd1);
    check("tgt_addr",  {32'd0, bus.mem_addr},  64'h40);
    check("fsm_left_flush", {63'd0, dut_state == flush_code}, 64'd0);
    step(1); @(negedge clk);                           // c7
    check("c7_valid", {63'd0, bus.instr_valid}, 64'd0);
    step(1); @(negedge clk);                           // c8
    check("tgt_valid", {63'd0, bus.instr_valid}, 64'd1);
    check("tgt_pc",    {32'd0, bus.instr_pc},    64'h40);
    check("tgt_instr", {32'd0, bus.instr},       {32'd0, 32'hD000_0040});
    step(3);
    check("br_log0", {32'd0, log_at(0)}, 64'd0);
    check("br_log1", {32'd0, log_at(1)}, 64'd1);
    check("br_log2", {32'd0, log_at(2)}, 64'h40);
    check("br_log3", {32'd0, log_at(3)}, 64'h41);

    // Backpressure: ready low through c5.
    apply_reset(1'b0);
    step(3); @(negedge clk);                           // c3
    check("bp_c3_instr", {32'd0, bus.instr}, {32'd0, 32'hD000_0000});
    step(2);                                           // c5
    check("bp_reads", rd_cnt, 64'd2);
    @(negedge clk);
    check("bp_valid", {63'd0, bus.instr_valid}, 64'd1);
    check("bp_instr", {32'd0, bus.instr},       {32'd0, 32'hD000_0000});
    check("bp_pc",    {32'd0, bus.instr_pc},    64'd0);
    step(1);
    bus.instr_ready = 1'b1;
    step(7);
    for (int i = 0; i < 4; i++) check("bp_order", {32'd0, log_at(i)}, i);

    // Branch in the same cycle as a pop, second buffered word dropped.
    apply_reset(1'b0);
    step(6);                                           // c6
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h80;
    @(negedge clk);
    check("bp_br_valid", {63'd0, bus.instr_valid}, 64'd1);
    check("bp_br_pc",    {32'd0, bus.instr_pc},    64'd0);
    step(1);
    bus.branch_valid = 1'b0;
    step(6);
    check("bp_br_log0", {32'd0, log_at(0)}, 64'd0);
    check("bp_br_log1", {32'd0, log_at(1)}, 64'h80);
    check("bp_br_log2", {32'd0, log_at(2)}, 64'h81);

    // Mid-run reset with two words buffered.
    apply_reset(1'b0);
    step(5); @(negedge clk);
    check("mr_pre_valid", {63'd0, bus.instr_valid}, 64'd1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pop_log.delete();
    @(negedge clk);
    check("mr_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("mr_instr", {32'd0, bus.instr},       64'd0);
    check("mr_pc",    {32'd0, bus.instr_pc},    64'd0);
    check("mr_rd_en", {63'd0, bus.mem_rd_en},   64'd0);
    step(1);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("mr_refetch_en",   {63'd0, bus.mem_rd_en}, 64'd1);
    check("mr_refetch_addr", {32'd0, bus.mem_addr},  {32'd0, RESET_PC});
    step(5);
    check("mr_log0", {32'd0, log_at(0)}, 64'd0);
    check("mr_log1", {32'd0, log_at(1)}, 64'd1);

    // Branch ignored in RESET; branch during FLUSH takes the newer target.
    apply_reset(1'b1);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h99;
    @(negedge clk);                                    // c0
    check("rb_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
    step(1);
    bus.branch_valid = 1'b0;
    @(negedge clk);                                    // c1
    check("rb_ignored_en",   {63'd0, bus.mem_rd_en}, 64'd1);
    check("rb_ignored_addr", {32'd0, bus.mem_addr},  64'd0);
    step(2);                                           // c3
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h50;
    @(negedge clk);
    check("ra_pop_pc", {32'd0, bus.instr_pc}, 64'd0);
    step(1);                                           // c4, in FLUSH
    bus.branch_target = 32'h60;
    @(negedge clk);
    check("ra_addr50", {32'd0, bus.mem_addr},  64'h50);
    check("ra_rd_en4", {63'd0, bus.mem_rd_en}, 64'd0);
    step(1);                                           // c5
    bus.branch_valid = 1'b0;
    @(negedge clk);
    check("ra_addr60", {32'd0, bus.mem_addr},  64'h60);
    check("ra_rd_en5", {63'd0, bus.mem_rd_en}, 64'd0);
    step(1); @(negedge clk);                           // c6
    check("ra_issue", {63'd0, bus.mem_rd_en}, 64'd1);
    step(4);
    check("ra_log0", {32'd0, log_at(0)}, 64'd0);
    check("ra_log1", {32'd0, log_at(1)}, 64'h60);
    check("ra_log2", {32'd0, log_at(2)}, 64'h61);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
